// File: rtl/data_mem_bus.sv
// data_mem_bus
//   Data-side bus of the single-cycle RV32I core. It decodes the core's data
//   address into a byte-addressable RAM and a small peripheral page:
//     0x0020_0000 KBD_DATA   (RO) pops the keyboard FIFO, returns head code
//     0x0020_0004 KBD_STATUS (RW) {count[12:8], ovf, full, not_empty}; any store clears ovf
//     0x0020_0008 LED        (RW) 16-bit register, byte lanes 0..1
//     0x0020_000C CYCLE      (RO) free-running cycle counter
//     0x0020_0010 HEX        (RW) 32-bit display register
//   Loads are sampled on the rising edge into dataout. Stores commit on the
//   falling edge of the same clock.
//
// Ports
//   clock      single clock (loads/FIFO on rise, stores on fall)
//   reset      asynchronous active-low reset
//   addr       byte address
//   datain     store data
//   memop      RV32I funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   we         store enable
//   re         load strobe; only a load may pop the FIFO
//   dataout    registered, extended load data
//   kbd_valid  scan-code push request
//   kbd_code   scan code
//   kbd_ready  FIFO not full
//   led        LED register
//   hex        HEX display register
module data_mem_bus #(
  parameter int RAM_AW  = 14,
  parameter int FIFO_AW = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic [2:0]  memop,
  input  logic        we,
  input  logic        re,
  output logic [31:0] dataout,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_code,
  output logic        kbd_ready,
  output logic [15:0] led,
  output logic [31:0] hex
);

  localparam int          NUM_LANES = 4;
  localparam int          RAM_WORDS = 1 << RAM_AW;
  localparam int          DEPTH     = 1 << FIFO_AW;
  localparam int          CW        = FIFO_AW + 1;
  localparam logic [31:0] RAM_BASE  = 32'h0010_0000;
  localparam logic [31:0] RAM_BYTES = 32'(4) << RAM_AW;

  // Peripheral word addresses (addr[31:2]).
  localparam logic [29:0] A_KBD  = 30'h0008_0000;
  localparam logic [29:0] A_STAT = 30'h0008_0001;
  localparam logic [29:0] A_LED  = 30'h0008_0002;
  localparam logic [29:0] A_CYC  = 30'h0008_0003;
  localparam logic [29:0] A_HEX  = 30'h0008_0004;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [31:0]       ram_off;
  logic              ram_hit;
  logic [RAM_AW-1:0] ram_idx;
  logic [29:0]       word_a;
  logic              kbd_hit, stat_hit, led_hit, cyc_hit, hex_hit;

  assign ram_off  = addr - RAM_BASE;
  assign ram_hit  = (addr >= RAM_BASE) && (ram_off < RAM_BYTES);
  // RAM base is aligned to the RAM size, so the low address bits index directly.
  assign ram_idx  = addr[RAM_AW+1:2];
  assign word_a   = addr[31:2];
  assign kbd_hit  = (word_a == A_KBD);
  assign stat_hit = (word_a == A_STAT);
  assign led_hit  = (word_a == A_LED);
  assign cyc_hit  = (word_a == A_CYC);
  assign hex_hit  = (word_a == A_HEX);

  // ---------------------------------------------------------------------------
  // Store lane steering: byte enables plus data replicated onto every lane so
  // that each enabled lane simply takes its own slice.
  // ---------------------------------------------------------------------------
  logic [NUM_LANES-1:0] be;
  logic [31:0]          wdata;

  always_comb begin
    be    = 4'b1111;
    wdata = datain;
    case (memop[1:0])
      2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{datain[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{datain[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = datain;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Data RAM: one byte-wide array per lane, written on the falling edge.
  // Contents are not reset; a store while reset is asserted is dropped.
  // ---------------------------------------------------------------------------
  logic [NUM_LANES-1:0][7:0] ram_rd;
  logic                      ram_we;

  assign ram_we = we & reset & ram_hit;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem [RAM_WORDS];

    always_ff @(negedge clock) begin
      if (ram_we && be[l]) mem[ram_idx] <= wdata[8*l +: 8];
    end

    assign ram_rd[l] = mem[ram_idx];
  end

  // ---------------------------------------------------------------------------
  // Keyboard FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]         fifo_q [DEPTH];
  logic [FIFO_AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               full, empty, load, pop, push, ovf_set;

  assign full      = (cnt_q == CW'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign kbd_ready = ~full;
  assign load      = re & ~we;
  assign pop       = load & kbd_hit & ~empty;
  // A pop in the same edge frees a slot, so a full FIFO still accepts the push
  // even though kbd_ready is low for that cycle.
  assign push      = kbd_valid & (~full | pop);
  assign ovf_set   = kbd_valid & full & ~pop;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) fifo_q[wr_ptr_q] <= kbd_code;
  end

  // ---------------------------------------------------------------------------
  // Overflow flag: set on the rising edge, cleared by a store on the falling
  // edge. Each edge owns its own register; the falling-edge side flips a
  // toggle and the rising-edge side acknowledges it, so a clear is pending
  // while the two differ.
  // ---------------------------------------------------------------------------
  logic ovf_q, ovf_d, clr_tgl_q, clr_ack_q, ovf_eff;

  assign ovf_eff = ovf_q & ~(clr_tgl_q ^ clr_ack_q);
  assign ovf_d   = ovf_eff | ovf_set;

  // ---------------------------------------------------------------------------
  // Read mux and extension
  // ---------------------------------------------------------------------------
  logic [31:0] cyc_q;
  logic [15:0] led_q, led_d;
  logic [31:0] hex_q, hex_d;
  logic [31:0] rword, stat, shifted, ld_val;

  always_comb begin
    stat          = 32'h0;
    stat[0]       = ~empty;
    stat[1]       = full;
    stat[2]       = ovf_eff;
    stat[8 +: CW] = cnt_q;
  end

  always_comb begin
    rword = 32'h0;
    if (ram_hit)       rword = ram_rd;
    else if (kbd_hit)  rword = empty ? 32'h0 : {24'h0, fifo_q[rd_ptr_q]};
    else if (stat_hit) rword = stat;
    else if (led_hit)  rword = {16'h0, led_q};
    else if (cyc_hit)  rword = cyc_q;
    else if (hex_hit)  rword = hex_q;
  end

  always_comb begin
    shifted = rword >> {addr[1:0], 3'b000};
    ld_val  = rword;
    case (memop[1:0])
      2'b00:   ld_val = {{24{shifted[7] & ~memop[2]}}, shifted[7:0]};
      2'b01:   ld_val = addr[1] ? {{16{rword[31] & ~memop[2]}}, rword[31:16]}
                                : {{16{rword[15] & ~memop[2]}}, rword[15:0]};
      default: ld_val = rword;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Rising-edge state: FIFO pointers, overflow, cycle counter, load data
  // ---------------------------------------------------------------------------
  logic [31:0] dataout_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      clr_ack_q <= 1'b0;
      cyc_q     <= 32'h0;
      dataout_q <= 32'h0;
    end else begin
      cyc_q     <= cyc_q + 32'h1;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      clr_ack_q <= clr_tgl_q;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) dataout_q <= ld_val;
    end
  end

  // ---------------------------------------------------------------------------
  // Falling-edge state: peripheral stores
  // ---------------------------------------------------------------------------
  always_comb begin
    led_d = led_q;
    hex_d = hex_q;
    for (int l = 0; l < 2; l++) begin
      if (be[l]) led_d[8*l +: 8] = wdata[8*l +: 8];
    end
    for (int l = 0; l < NUM_LANES; l++) begin
      if (be[l]) hex_d[8*l +: 8] = wdata[8*l +: 8];
    end
  end

  always_ff @(negedge clock or negedge reset) begin
    if (!reset) begin
      led_q     <= 16'h0;
      hex_q     <= 32'h0;
      clr_tgl_q <= 1'b0;
    end else if (we) begin
      if (led_hit)  led_q     <= led_d;
      if (hex_hit)  hex_q     <= hex_d;
      if (stat_hit) clr_tgl_q <= ~clr_tgl_q;
    end
  end

  assign dataout = dataout_q;
  assign led     = led_q;
  assign hex     = hex_q;

endmodule

// File: doc/data_mem_bus.md
# data_mem_bus

Memory-mapped data-side bus for the single-cycle RV32I core. It decodes the core's data address into a byte-addressable data RAM and a small peripheral page: a keyboard scan-code FIFO, an LED register, a HEX display register and a free-running cycle counter. It sits directly downstream of the core's data-memory port (address, write data, MemOp, write enable) and returns load data to the core's write-back mux.

## Interface

Parameters:
- RAM_AW, 14, RAM word-address width. 2^RAM_AW 32-bit words; 64 KiB at the default.
- FIFO_AW, 4, keyboard FIFO pointer width. Depth is 2^FIFO_AW, 16 at the default.

Ports:
- clock  in  1  single clock. Loads sample on the rising edge; stores commit on the falling edge of the same clock.
- reset  in  1  asynchronous, active-low.
- addr  in  32  byte address, the core's ALU result.
- datain  in  32  store data, the core's BusB.
- memop  in  3  RV32I funct3. 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
- we  in  1  store enable.
- re  in  1  load strobe, the core's MemtoReg. Only a load with re=1 may pop the FIFO.
- dataout  out  32  registered load data, sign- or zero-extended per memop.
- kbd_valid  in  1  scan-code push request.
- kbd_code  in  8  scan code.
- kbd_ready  out  1  high when the FIFO is not full.
- led  out  16  LED register.
- hex  out  32  HEX display register; 8 nibbles.

## Operation

Address map (decode on addr[31:0]):
- 0x0010_0000–0x0010_0000+4·2^RAM_AW−1: data RAM.
- 0x0020_0000 KBD_DATA (read only):
  - A load pops the FIFO and returns the head code zero-extended to 32 bits.
  - A load on an empty FIFO returns 0 and leaves the pointers unchanged.
- 0x0020_0004 KBD_STATUS (read/write):
  - Read fields: bit0 = not empty, bit1 = full, bit2 = overflow (sticky), bits[12:8] = count. All other bits read 0.
  - Any store clears overflow.
- 0x0020_0008 LED: read/write, bits[15:0]. A word store writes all 16 bits; a byte or half store writes only its lanes within [15:0].
- 0x0020_000C CYCLE: read only, 32-bit. Increments every rising edge and wraps 0xFFFF_FFFF→0.
- 0x0020_0010 HEX: read/write, full byte-lane writes.

Unmapped addresses: loads return 0; stores are ignored.

Alignment:
- Word accesses ignore addr[1:0].
- Half accesses ignore addr[0]; addr[1] selects the lane.
- Byte accesses use addr[1:0] as the lane. Little-endian.

RAM behaviour:
- Byte-enable writes: a byte store writes 1 lane, a half store 2 lanes, a word store 4 lanes.
- RAM contents are not reset.

FIFO behaviour:
- A push occurs when kbd_valid && kbd_ready.
- kbd_valid while full: the code is dropped, overflow is set, and the pointers are unchanged.
- Push and pop in the same cycle: both occur and count is unchanged.
- When full, a pop and kbd_valid in the same cycle: the pop frees a slot, the push is accepted, and overflow is not set. kbd_ready is combinational from the registered count, so it stays 0 in that cycle, but the push is accepted anyway.
- Pointers wrap modulo 2^FIFO_AW. Count spans 0..2^FIFO_AW.

Load path:
- Read mux, extension and FIFO pop are evaluated at the rising edge when re=1 and we=0.
- Extension rules: byte signed extends bit7; half signed extends bit15; memop 100/101 zero-extend.
- re=0 at a rising edge: dataout holds its previous value.

Store path:
- Committed at the falling edge when we=1.
- re and we both high: store only; no pop, and dataout holds.

## Timing

- Reset (async assert, sync-safe release): dataout=0, led=0, hex=0, CYCLE=0, FIFO pointers=0, count=0, overflow=0, kbd_ready=1.
- Load latency: addr/memop/re stable before a rising edge; dataout is valid after that edge and held through the following falling edge, where the core's write-back samples it.
- Store: addr/datain/memop/we stable before the falling edge; the new value is visible to a load at the next rising edge.
- FIFO push is sampled on the rising edge. Status read in the same cycle as a push reflects the pre-push count.
- CYCLE read returns the value before that edge's increment.
- Reset asserted mid-operation: every register clears immediately; a store in flight is lost.

## Test plan

- Reset, then lw 0x0020_0004 → dataout=0x0000_0000 and kbd_ready=1. Read CYCLE after 10 rising edges → 10.
- sw 0x1234_5678 @0x0010_0000, then:
  - lb @+1 → 0x0000_0056.
  - lh @+2 → 0x0000_1234.
  - sb 0xAB @+3, then lw → 0xAB34_5678.
  - lb @+3 → 0xFFFF_FFAB; lbu @+3 → 0x0000_00AB.
- Push codes 0x01..0x10 (16 pushes):
  - kbd_ready=0 and status=0x0000_1003.
  - Push 0x55 → dropped; status bit2=1.
  - 16 KBD_DATA loads return 0x01..0x10; a 17th load returns 0.
  - sw to status clears bit2.
- FIFO full, pop and kbd_valid (0x77) in the same cycle → count stays 16 and overflow stays 0. Subsequent pops return 0x02..0x10, then 0x77.
- sh 0xBEEF @0x0020_000A → led unchanged (lane 2 lies outside [15:0]); sh @0x0020_0008 → led=0xBEEF. sw @0x0030_0000 is ignored; lw there → 0.
- Assert reset during a burst of stores and pushes → all outputs and counters read their reset values at the next load.
